// File: rtl/aes_mixcol_seq.sv
// rtl/aes_mixcol_seq.sv - sequential AES MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per RUN cycle
// Optional AES_MIXCOL_BYPASS_EN adds a bypass input that passes the state through unmodified.
module aes_mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
`ifdef AES_MIXCOL_BYPASS_EN
  input  logic         bypass,
`endif
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  localparam int         NUM_RUN  = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(NUM_RUN - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   out_q, out_d;
  logic           inv_q, inv_d;
  logic           bypass_act;
  logic [1:0]     sel;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // 2x/4x/8x multiples are shared by both directions; every coefficient is an XOR of them
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_i);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      if (inv_i)
        res[31-8*r -: 8] = (x8[2'(r)]   ^ x4[2'(r)]   ^ x2[2'(r)])
                         ^ (x8[2'(r+1)] ^ x2[2'(r+1)] ^ a[2'(r+1)])
                         ^ (x8[2'(r+2)] ^ x4[2'(r+2)] ^ a[2'(r+2)])
                         ^ (x8[2'(r+3)] ^ a[2'(r+3)]);
      else
        res[31-8*r -: 8] = x2[2'(r)] ^ (x2[2'(r+1)] ^ a[2'(r+1)]) ^ a[2'(r+2)] ^ a[2'(r+3)];
    end
    return res;
  endfunction

`ifdef AES_MIXCOL_BYPASS_EN
  logic bypass_q, bypass_d;
  assign bypass_act = bypass_q;
`else
  assign bypass_act = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    inv_d   = inv_q;
    sel     = '0;
`ifdef AES_MIXCOL_BYPASS_EN
    bypass_d = bypass_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          inv_d   = inv;
          cnt_d   = '0;
          state_d = RUN;
`ifdef AES_MIXCOL_BYPASS_EN
          bypass_d = bypass;
`endif
        end
      end
      RUN: begin
        // Only COLS_PER_CYCLE mix units exist; the counter steers them across the state
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          sel = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
          if (!bypass_act)
            work_d[127-32*int'(sel) -: 32] = mix_col(work_q[127-32*int'(sel) -: 32], inv_q);
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          out_d   = work_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass_q <= bypass_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign state_out = out_q;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// tb/tb_aes_mixcol_seq.sv - bench for aes_mixcol_seq at 1, 2 and 4 columns per cycle
// Define AES_MIXCOL_BYPASS_EN to also exercise the bypass input.
module tb_aes_mixcol_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         inv       [3];
  logic [127:0] state_in  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];
  logic         busy      [3];
`ifdef AES_MIXCOL_BYPASS_EN
  logic         bypass    [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] V_A  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_B  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V_C6 = {4{32'hc6c6c6c6}};
  localparam logic [127:0] V_D4 = {4{32'hd4d4d4d5}};
  localparam logic [127:0] V_D5 = {4{32'hd5d5d7d6}};

  always #5 clk = ~clk;

  aes_mixcol_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .inv(inv[0]),
`ifdef AES_MIXCOL_BYPASS_EN
    .bypass(bypass[0]),
`endif
    .state_in(state_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .state_out(state_out[0]), .busy(busy[0]));

  aes_mixcol_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .inv(inv[1]),
`ifdef AES_MIXCOL_BYPASS_EN
    .bypass(bypass[1]),
`endif
    .state_in(state_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .state_out(state_out[1]), .busy(busy[1]));

  aes_mixcol_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .inv(inv[2]),
`ifdef AES_MIXCOL_BYPASS_EN
    .bypass(bypass[2]),
`endif
    .state_in(state_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .state_out(state_out[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: carry-less product followed by long division by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
    logic [7:0]   co [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (iv) begin co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09; end
    else    begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(co[j], s[127 - 32*c - 8*((r + j) % 4) -: 8]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic byp_of(input int k);
`ifdef AES_MIXCOL_BYPASS_EN
    return bypass[k];
`else
    return (k < 0);
`endif
  endfunction

  // Transaction-level model: pending flag, cycles since accept, expected and last result
  logic         m_pend [3] = '{default: 1'b0};
  int           m_cnt  [3] = '{default: 0};
  logic [127:0] m_exp  [3] = '{default: '0};
  logic [127:0] m_last [3] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_pend[k] <= 1'b0;
        m_cnt[k]  <= 0;
        m_last[k] <= '0;
      end else if (m_pend[k]) begin
        if (m_cnt[k] >= (4 >> k) && out_ready[k]) begin
          m_pend[k] <= 1'b0;
          m_last[k] <= m_exp[k];
        end else if (m_cnt[k] < (4 >> k)) begin
          m_cnt[k] <= m_cnt[k] + 1;
        end
      end else if (in_valid[k]) begin
        m_pend[k] <= 1'b1;
        m_cnt[k]  <= 0;
        m_exp[k]  <= byp_of(k) ? state_in[k] : ref_mix(state_in[k], inv[k]);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic         ev;
      logic [127:0] eo;
      ev = m_pend[k] && (m_cnt[k] >= (4 >> k));
      eo = ev ? m_exp[k] : m_last[k];
      chk($sformatf("cyc_in_ready[%0d]", k),  128'(in_ready[k]),  128'(!m_pend[k]));
      chk($sformatf("cyc_busy[%0d]", k),      128'(busy[k]),      128'(m_pend[k]));
      chk($sformatf("cyc_out_valid[%0d]", k), 128'(out_valid[k]), 128'(ev));
      chk($sformatf("cyc_state_out[%0d]", k), state_out[k], eo);
    end
  end

  task automatic send(input int k, input logic [127:0] st, input logic iv, input logic bp);
    int t;
    @(posedge clk); #1;
    state_in[k] = st;
    inv[k]      = iv;
`ifdef AES_MIXCOL_BYPASS_EN
    bypass[k]   = bp;
`else
    if (bp) chk("bypass_unavailable", 128'(bp), 128'(0));
`endif
    in_valid[k] = 1'b1;
    t = 0;
    while (!in_ready[k] && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk($sformatf("send_timeout[%0d]", k), 128'(t), 128'(0));
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic run_one(input int k, input logic [127:0] st, input logic iv, input logic bp,
                         output logic [127:0] res, output int lat);
    out_ready[k] = 1'b1;
    send(k, st, iv, bp);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin @(posedge clk); #1; lat++; end
    res = state_out[k];
  endtask

  task automatic rand_drive(input int k, input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      in_valid[k]  = 1'($urandom_range(0, 1));
      state_in[k]  = {$urandom, $urandom, $urandom, $urandom};
      inv[k]       = 1'($urandom_range(0, 1));
      out_ready[k] = ($urandom_range(0, 3) != 0);
`ifdef AES_MIXCOL_BYPASS_EN
      bypass[k]    = ($urandom_range(0, 3) == 0);
`endif
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, snap, x;
    int           lat, t;
    logic         seen;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; inv[k] = 1'b0; state_in[k] = '0; out_ready[k] = 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass[k] = 1'b0;
`endif
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k),  128'(in_ready[k]),  128'(1));
      chk($sformatf("rst_out_valid[%0d]", k), 128'(out_valid[k]), 128'(0));
      chk($sformatf("rst_busy[%0d]", k),      128'(busy[k]),      128'(0));
      chk($sformatf("rst_state_out[%0d]", k), state_out[k], 128'(0));
    end
    rst_n = 1'b1;

    chk("model_fwd", ref_mix(V_A, 1'b0), V_B);
    chk("model_inv", ref_mix(V_B, 1'b1), V_A);
    chk("model_d4",  ref_mix(V_D4, 1'b0), V_D5);

    run_one(0, V_A, 1'b0, 1'b0, res, lat);
    chk("t1_fwd", res, V_B);
    chk("t1_lat", 128'(lat), 128'(4));

    for (int k = 0; k < 3; k++) begin
      run_one(k, V_B, 1'b1, 1'b0, res, lat);
      chk($sformatf("t2_inv[%0d]", k), res, V_A);
      chk($sformatf("t2_lat[%0d]", k), 128'(lat), 128'(4 >> k));
    end

    out_ready[0] = 1'b0;
    send(0, V_A, 1'b0, 1'b0);
    t = 0;
    while (!out_valid[0] && t < 20) begin @(posedge clk); #1; t++; end
    snap = state_out[0];
    chk("t3_first", snap, V_B);
    repeat (10) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", 128'(out_valid[0]), 128'(1));
      chk("t3_hold_data",  state_out[0], snap);
      chk("t3_hold_ready", 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_valid", 128'(out_valid[0]), 128'(0));
    chk("t3_release_ready", 128'(in_ready[0]), 128'(1));

    x = {$urandom, $urandom, $urandom, $urandom};
    out_ready[1] = 1'b1;
    send(1, x, 1'b1, 1'b0);
    state_in[1] = V_C6;
    inv[1]      = 1'b0;
    t = 0;
    while (!out_valid[1] && t < 20) begin
      @(posedge clk); #1; t++;
      state_in[1] = ~state_in[1];
      inv[1]      = ~inv[1];
    end
    chk("t4_latched", state_out[1], ref_mix(x, 1'b1));
    run_one(1, V_C6, 1'b0, 1'b0, res, lat);
    chk("t4_c6", res, V_C6);

`ifdef AES_MIXCOL_BYPASS_EN
    run_one(0, V_D4, 1'b0, 1'b1, res, lat);
    chk("t6_bypass", res, V_D4);
    chk("t6_bypass_lat", 128'(lat), 128'(4));
    run_one(0, V_D4, 1'b0, 1'b0, res, lat);
    chk("t6_nobypass", res, V_D5);
`endif

    out_ready[0] = 1'b1;
    send(0, V_A, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 128'(out_valid[0]), 128'(0));
    chk("t5_busy",      128'(busy[0]),      128'(0));
    chk("t5_state_out", state_out[0], 128'(0));
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    chk("t5_no_output", 128'(seen), 128'(0));

    fork
      rand_drive(0, 400);
      rand_drive(1, 400);
      rand_drive(2, 400);
    join

    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("drain_idle[%0d]", k), 128'(in_ready[k]), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
